// File: rtl/axi_rd_responder.sv
// axi_rd_responder: AXI4 read responder serving INCR/FIXED bursts from a preloadable word memory
module axi_rd_responder #(
  parameter int AXI_DATA_WIDTH = 256,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH = 1,
  parameter int AXI_BURST_WIDTH = 8,
  parameter int MEM_ADDR_W = 10,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [AXI_ADDR_WIDTH-1:0]  s_axi_araddr,
  input  logic [AXI_BURST_WIDTH-1:0] s_axi_arlen,
  input  logic [2:0]                 s_axi_arsize,
  input  logic [1:0]                 s_axi_arburst,
  input  logic [AXI_ID_WIDTH-1:0]    s_axi_arid,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]  s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic [AXI_ID_WIDTH-1:0]    s_axi_rid,
  output logic                       s_axi_rlast,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  input  logic                       load_en,
  input  logic [MEM_ADDR_W-1:0]      load_addr,
  input  logic [AXI_DATA_WIDTH-1:0]  load_data,
  output logic                       busy
);
  localparam int SH = $clog2(AXI_DATA_WIDTH / 8);
  localparam int LW = AXI_BURST_WIDTH + 1;
  localparam logic [2:0] SZ = 3'(SH);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state_q;
  logic arready_q;
  logic [AXI_ADDR_WIDTH-1:0] idx_q;
  logic [LW-1:0] left_q;
  logic fixed_q, slv_q, low_q;
  logic [AXI_ID_WIDTH-1:0] rid_q;
  logic rd_v_q, rd_last_q;
  logic [1:0] rd_resp_q;
  logic [AXI_DATA_WIDTH-1:0] mem_q;
  logic [AXI_DATA_WIDTH-1:0] mem [2**MEM_ADDR_W];
  logic [AXI_DATA_WIDTH-1:0] fd_q [2];
  logic [1:0] fr_q [2];
  logic [1:0] fl_q;
  logic wp_q, rp_q;
  logic [1:0] cnt_q, cnt_d;
  logic [AXI_ADDR_WIDTH-1:0] off;
  logic issue, pop, dec;
  assign off = s_axi_araddr - BASE_ADDR;
  assign dec = low_q | (|idx_q[AXI_ADDR_WIDTH-1:MEM_ADDR_W]);
  assign pop = s_axi_rvalid & s_axi_rready;
  // occupancy counts the beat leaving this cycle as already gone, so a full-rate stream never bubbles
  assign issue = (state_q == BURST) && (left_q != '0) &&
                 ((cnt_q + {1'b0, rd_v_q} - {1'b0, pop}) < 2'd2);
  assign cnt_d = cnt_q + {1'b0, rd_v_q} - {1'b0, pop};
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid = cnt_q != 2'd0;
  assign s_axi_rdata = fd_q[rp_q];
  assign s_axi_rresp = fr_q[rp_q];
  assign s_axi_rlast = s_axi_rvalid & fl_q[rp_q];
  assign s_axi_rid = rid_q;
  assign busy = state_q == BURST;
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
    if (issue) mem_q <= mem[idx_q[MEM_ADDR_W-1:0]];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      arready_q <= 1'b0;
      idx_q <= '0;
      left_q <= '0;
      fixed_q <= 1'b0;
      slv_q <= 1'b0;
      low_q <= 1'b0;
      rid_q <= '0;
      rd_v_q <= 1'b0;
      rd_last_q <= 1'b0;
      rd_resp_q <= 2'b00;
      fd_q[0] <= '0;
      fd_q[1] <= '0;
      fr_q[0] <= 2'b00;
      fr_q[1] <= 2'b00;
      fl_q <= 2'b00;
      wp_q <= 1'b0;
      rp_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (state_q == IDLE) begin
        if (arready_q && s_axi_arvalid) begin
          state_q <= BURST;
          arready_q <= 1'b0;
          idx_q <= off >> SH;
          left_q <= LW'(s_axi_arlen) + LW'(1);
          fixed_q <= s_axi_arburst == 2'b00;
          slv_q <= (s_axi_arsize != SZ) || s_axi_arburst[1];
          low_q <= s_axi_araddr < BASE_ADDR;
          rid_q <= s_axi_arid;
        end else begin
          arready_q <= 1'b1;
        end
      end else if (pop && s_axi_rlast) begin
        state_q <= IDLE;
        arready_q <= 1'b1;
      end
      if (issue) begin
        left_q <= left_q - LW'(1);
        idx_q <= fixed_q ? idx_q : idx_q + AXI_ADDR_WIDTH'(1);
        rd_resp_q <= slv_q ? 2'b10 : dec ? 2'b11 : 2'b00;
        rd_last_q <= left_q == LW'(1);
      end
      rd_v_q <= issue;
      if (rd_v_q) begin
        fd_q[wp_q] <= (rd_resp_q == 2'b00) ? mem_q : '0;
        fr_q[wp_q] <= rd_resp_q;
        fl_q[wp_q] <= rd_last_q;
        wp_q <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_axi_rd_responder.sv
// tb_axi_rd_responder: vector table plus randomized bursts checked against a word-array reference model
module tb_axi_rd_responder;
  localparam int DW = 256;
  localparam int MW = 10;
  localparam int DEPTH = 1 << MW;
  localparam logic [31:0] BASE = 32'h0000_1000;
  typedef struct {
    bit pre_en;
    int pre_addr;
    logic [DW-1:0] pre_data;
    logic [31:0] addr;
    logic [7:0] len;
    logic [2:0] sz;
    logic [1:0] b;
    logic id;
    bit rnd;
    logic [DW-1:0] ed0;
    logic [1:0] er0;
    logic [1:0] erl;
  } rec_t;
  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] araddr = '0;
  logic [7:0] arlen = '0;
  logic [2:0] arsize = '0;
  logic [1:0] arburst = '0;
  logic arid = 1'b0, arvalid = 1'b0, arready;
  logic [DW-1:0] rdata;
  logic [1:0] rresp;
  logic rid, rlast, rvalid, rready = 1'b0;
  logic load_en = 1'b0;
  logic [MW-1:0] load_addr = '0;
  logic [DW-1:0] load_data = '0;
  logic busy;
  logic [DW-1:0] mdl [DEPTH];
  int checks = 0, errors = 0;
  rec_t vec [7];

  axi_rd_responder #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(32), .AXI_ID_WIDTH(1),
    .AXI_BURST_WIDTH(8), .MEM_ADDR_W(MW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arid(arid),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_rdata(rdata),
    .s_axi_rresp(rresp), .s_axi_rid(rid), .s_axi_rlast(rlast), .s_axi_rvalid(rvalid),
    .s_axi_rready(rready), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load(input int a, input logic [DW-1:0] d);
    load_en = 1'b1;
    load_addr = MW'(a);
    load_data = d;
    @(posedge clk);
    mdl[a] = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Reference: a burst is arlen+1 word reads; bad size/type is SLVERR, out-of-window words DECERR
  task automatic exp_beat(input rec_t r, input int i, output logic [DW-1:0] d, output logic [1:0] rs);
    longint idx;
    d = '0;
    if (r.sz != 3'd5 || r.b > 2'd1) rs = 2'b10;
    else if (r.addr < BASE) rs = 2'b11;
    else begin
      idx = longint'((r.addr - BASE) / 32) + ((r.b == 2'd1) ? i : 0);
      if (idx >= DEPTH) rs = 2'b11;
      else begin
        rs = 2'b00;
        d = mdl[int'(idx)];
      end
    end
  endtask

  task automatic start_ar(input rec_t r, output bit ok);
    int n = 0;
    araddr = r.addr; arlen = r.len; arsize = r.sz; arburst = r.b; arid = r.id;
    arvalid = 1'b1;
    while (!arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = arready;
    chk("ar_accept", {255'b0, arready}, 1);
    @(negedge clk);
    arvalid = 1'b0;
    if (ok) begin
      chk("busy_after_ar", {255'b0, busy}, 1);
      chk("arready_in_burst", {255'b0, arready}, 0);
    end
  endtask

  task automatic collect(input rec_t r, output logic [DW-1:0] d0, output logic [1:0] r0, output logic [1:0] rl);
    int beats = 0, e = 0, first = -1, lastat = -1;
    bit stall = 0;
    logic [DW-1:0] sd, ed;
    logic [1:0] sr, er;
    logic sl;
    d0 = '0; r0 = '0; rl = '0;
    while (beats <= int'(r.len) && e < 400) begin
      if (rvalid) begin
        if (first < 0) first = e;
        if (beats == int'(r.len) && lastat < 0) lastat = e;
        if (stall) begin
          chk("stall_rdata", rdata, sd);
          chk("stall_rresp", {254'b0, rresp}, {254'b0, sr});
          chk("stall_rlast", {255'b0, rlast}, {255'b0, sl});
        end
        rready = r.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rready) begin
          exp_beat(r, beats, ed, er);
          chk("rdata", rdata, ed);
          chk("rresp", {254'b0, rresp}, {254'b0, er});
          chk("rlast", {255'b0, rlast}, {255'b0, beats == int'(r.len)});
          chk("rid", {255'b0, rid}, {255'b0, r.id});
          if (beats == 0) begin
            d0 = rdata;
            r0 = rresp;
          end
          rl = rresp;
          beats++;
          stall = 0;
        end else begin
          stall = 1;
          sd = rdata; sr = rresp; sl = rlast;
        end
      end else begin
        if (stall) chk("rvalid_held", {255'b0, rvalid}, 1);
        stall = 0;
        rready = r.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(negedge clk);
      e++;
    end
    rready = 1'b0;
    chk("beat_count", beats, int'(r.len) + 1);
    if (!r.rnd) begin
      chk("first_rvalid_edge", first, 2);
      chk("last_beat_edge", lastat, int'(r.len) + 2);
    end
    chk("busy_end", {255'b0, busy}, 0);
    chk("arready_end", {255'b0, arready}, 1);
    chk("rvalid_end", {255'b0, rvalid}, 0);
  endtask

  task automatic run(input rec_t r, output logic [DW-1:0] d0, output logic [1:0] r0, output logic [1:0] rl);
    bit ok;
    d0 = '0; r0 = '0; rl = '0;
    if (r.pre_en) load(r.pre_addr, r.pre_data);
    start_ar(r, ok);
    if (ok) collect(r, d0, r0, rl);
  endtask

  initial begin
    logic [DW-1:0] d0;
    logic [1:0] r0, rl;
    rec_t r;
    bit ok;
    int p, t;
    vec[0] = '{0, 0, '0, BASE, 8'd3, 3'd5, 2'b01, 1'b1, 0, 256'hA0, 2'b00, 2'b00};
    vec[1] = '{0, 0, '0, BASE, 8'd3, 3'd5, 2'b01, 1'b0, 1, 256'hA0, 2'b00, 2'b00};
    vec[2] = '{1, 1, 256'h55, BASE + 32'd32, 8'd2, 3'd5, 2'b00, 1'b1, 0, 256'h55, 2'b00, 2'b00};
    vec[3] = '{0, 0, '0, BASE, 8'd1, 3'd2, 2'b01, 1'b0, 0, 256'h0, 2'b10, 2'b10};
    vec[4] = '{0, 0, '0, BASE, 8'd1, 3'd5, 2'b10, 1'b1, 0, 256'h0, 2'b10, 2'b10};
    vec[5] = '{1, DEPTH - 2, 256'hC0, BASE + 32'((DEPTH - 2) * 32), 8'd3, 3'd5, 2'b01, 1'b0, 0, 256'hC0, 2'b00, 2'b11};
    vec[6] = '{0, 0, '0, BASE + 32'd96, 8'd0, 3'd5, 2'b01, 1'b1, 0, 256'hA3, 2'b00, 2'b00};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", {255'b0, arready}, 0);
    chk("rst_rvalid", {255'b0, rvalid}, 0);
    chk("rst_busy", {255'b0, busy}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rlast", {255'b0, rlast}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("arready_after_rst", {255'b0, arready}, 1);
    for (int i = 0; i < DEPTH; i++)
      load(i, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < 4; i++) load(i, 256'hA0 + DW'(i));
    for (int i = 0; i < 7; i++) begin
      run(vec[i], d0, r0, rl);
      chk($sformatf("vec%0d_d0", i), d0, vec[i].ed0);
      chk($sformatf("vec%0d_resp0", i), {254'b0, r0}, {254'b0, vec[i].er0});
      chk($sformatf("vec%0d_resplast", i), {254'b0, rl}, {254'b0, vec[i].erl});
    end
    for (int i = 0; i < 40; i++) begin
      r = vec[0];
      r.addr = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, BASE - 1))
             : BASE + 32'($urandom_range(0, DEPTH + 6) * 32) + 32'($urandom_range(0, 31));
      r.len = 8'($urandom_range(0, 9));
      r.sz = ($urandom_range(0, 7) == 0) ? 3'd4 : 3'd5;
      r.b = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      r.id = 1'($urandom_range(0, 1));
      r.rnd = 1'($urandom_range(0, 1));
      run(r, d0, r0, rl);
    end
    r = vec[0];
    r.len = 8'd7;
    start_ar(r, ok);
    rready = 1'b1;
    p = 0; t = 0;
    while (p < 2 && t < 20) begin
      if (rvalid) p++;
      @(negedge clk);
      t++;
    end
    chk("two_beats_before_rst", p, 2);
    reset = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("midrst_rvalid", {255'b0, rvalid}, 0);
    chk("midrst_busy", {255'b0, busy}, 0);
    chk("midrst_arready", {255'b0, arready}, 0);
    chk("midrst_rdata", rdata, 0);
    chk("midrst_rid", {255'b0, rid}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("arready_after_midrst", {255'b0, arready}, 1);
    r = vec[0];
    r.addr = BASE + 32'd64;
    r.len = 8'd1;
    run(r, d0, r0, rl);
    chk("post_rst_d0", d0, 256'hA2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
